// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu shared types: funct3 access codes,
// FSM state encoding and access-size decode.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic logic [2:0] size_of(
    input logic [1:0] sz
  );
    logic [2:0] n;
    n = 3'd0;
    case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic f3_illegal(
    input logic [2:0] f3,
    input logic       we
  );
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // True when the access runs past byte lane 3.
  function automatic logic is_split(
    input logic [1:0] off,
    input logic [2:0] size
  );
    return ({2'b00, off} + {1'b0, size})
           > 4'd4;
  endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// Execute-side request/response and data-memory
// signals of the load/store unit.
interface rv32_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/rv32_lsu_align.sv
// Byte-lane alignment: store shift/strobe mask and
// load window shift with sign/zero extension.
module lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic        split,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [63:0] st_data,
  output logic [7:0]  st_mask,
  output logic [31:0] ld_data
);

  logic [2:0]  size;
  logic [7:0]  ones;
  logic [63:0] win;
  logic [31:0] sh;

  assign size = size_of(funct3[1:0]);
  assign ones = (8'd1 << size) - 8'd1;

  assign st_data = {32'b0, wdata}
                   << {off, 3'b000};
  assign st_mask = ones << off;

  // hi_word is the most recent read; lo_word
  // only matters for a word-crossing access.
  assign win = split ? {hi_word, lo_word}
                     : {32'b0, hi_word};
  assign sh  = 32'(win >> {off, 3'b000});

  always_comb begin
    ld_data = 32'b0;
    case (funct3)
      F3_B:  ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:  ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_W:  ld_data = sh;
      F3_BU: ld_data = {24'b0, sh[7:0]};
      F3_HU: ld_data = {16'b0, sh[15:0]};
      default: ld_data = 32'b0;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32 load/store unit: one request at a time,
// optional two-cycle split for word-crossing access.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int ALLOW_MISALIGN = 1,
  parameter int XLEN           = 32
) (
  input logic      CLK,
  input logic      RST,
  rv32_lsu_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;
  logic [31:0]     lo_q;

  logic        split_q;
  logic        split_req;
  logic        bad_req;
  logic [31:0] word;
  logic [63:0] st_data;
  logic [7:0]  st_mask;
  logic [31:0] ld_data;

  assign split_req = is_split(
    bus.req_addr[1:0],
    size_of(bus.req_funct3[1:0]));

  assign bad_req =
    f3_illegal(bus.req_funct3, bus.req_we) ||
    (split_req && (ALLOW_MISALIGN == 0));

  assign split_q = is_split(
    addr_q[1:0], size_of(f3_q[1:0]));

  assign word = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .funct3  (f3_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .split   (split_q),
    .lo_word (lo_q),
    .hi_word (bus.mem_rdata),
    .st_data (st_data),
    .st_mask (st_mask),
    .ld_data (ld_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid)
        state_d = bad_req ? RESP : FIRST;
      FIRST:  state_d = split_q ? SECOND : RESP;
      SECOND: state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = word;
    bus.mem_wdata = 32'b0;
    bus.mem_wstrb = 4'b0;
    unique case (state_q)
      IDLE: bus.req_ready = 1'b1;
      FIRST: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_wdata = st_data[31:0];
        bus.mem_wstrb = we_q ? st_mask[3:0]
                             : 4'b0;
      end
      SECOND: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = word + 32'd4;
        bus.mem_wdata = st_data[63:32];
        bus.mem_wstrb = we_q ? st_mask[7:4]
                             : 4'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'b0;
      bus.resp_err   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lo_q    <= 32'b0;
    end else begin
      bus.resp_valid <= (state_q == RESP);
      bus.resp_err   <= (state_q == RESP)
                        && err_q;
      bus.resp_rdata <=
        ((state_q == RESP) && !err_q && !we_q)
        ? ld_data : 32'b0;
      if ((state_q == IDLE) && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= bad_req;
      end
      // FIRST's read data arrives during SECOND.
      if (state_q == SECOND)
        lo_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Scoreboard bench for rv32_lsu with an 8-word
// memory model plus a no-misalign instance.
module tb_rv32_lsu;
  import rv32_lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          gap;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } acc_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rv32_lsu_if bus ();
  rv32_lsu_if bus0 ();

  rv32_lsu #(.ALLOW_MISALIGN(1), .XLEN(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  rv32_lsu #(.ALLOW_MISALIGN(0), .XLEN(32)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  resp_t rq[$];
  acc_t  mq[$];
  int    aq[$];
  int    cyc = 0;
  int    last_resp = 0;
  int    n_resp = 0;
  int    m0_en = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  logic [31:0] mem [8];
  logic [31:0] rd;

  assign bus.mem_rdata  = rd;
  assign bus0.mem_rdata = 32'h12345678;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(
    input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899AABB;
      mem[1] <= 32'h11223344;
      mem[7] <= 32'h55667788;
      rd <= 32'h0;
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we && bus.mem_wstrb[b])
          mem[bus.mem_addr[4:2]][8*b +: 8]
            <= bus.mem_wdata[8*b +: 8];
      rd <= mem[bus.mem_addr[4:2]];
    end
  end

  always @(negedge CLK) begin
    resp_t r;
    acc_t  m;
    int    a;
    if (bus0.mem_en === 1'b1) m0_en++;
    if (bus.req_valid && bus.req_ready)
      aq.push_back(cyc);
    if (bus.resp_valid === 1'b1) begin
      n_resp++;
      chk("resp_expected",
          32'(rq.size() > 0 && aq.size() > 0), 1);
      if (rq.size() > 0 && aq.size() > 0) begin
        r = rq.pop_front();
        a = aq.pop_front();
        chk("resp_rdata", bus.resp_rdata, r.rdata);
        chk("resp_err", 32'(bus.resp_err),
            32'(r.err));
        chk("latency", 32'(cyc - a), 32'(r.lat));
        if (r.gap != 0)
          chk("resp_gap", 32'(cyc - last_resp),
              32'(r.gap));
      end
      last_resp = cyc;
    end
    if (bus.mem_en === 1'b1) begin
      chk("mem_expected", 32'(mq.size() > 0), 1);
      if (mq.size() > 0) begin
        m = mq.pop_front();
        chk("mem_addr", bus.mem_addr, m.addr);
        chk("mem_we", 32'(bus.mem_we), 32'(m.we));
        chk("mem_wstrb", 32'(bus.mem_wstrb),
            32'(m.strb));
        chk("mem_wdata",
            bus.mem_wdata & lanes(bus.mem_wstrb),
            m.wdata);
      end
    end
  end

  task automatic exp_mem(input logic [31:0] addr,
                         input logic        we,
                         input logic [3:0]  strb,
                         input logic [31:0] wd);
    acc_t m;
    m.addr = addr;
    m.we = we;
    m.strb = strb;
    m.wdata = wd;
    mq.push_back(m);
  endtask

  task automatic issue(input logic        we,
                       input logic [2:0]  f3,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] erd,
                       input logic        eerr,
                       input int          lat,
                       input int          gap);
    resp_t r;
    int n;
    r.rdata = erd;
    r.err = eerr;
    r.lat = lat;
    r.gap = gap;
    rq.push_back(r);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.req_ready && n < 20);
    chk("accept", 32'(bus.req_ready), 1);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic m0_req(input logic [2:0]  f3,
                        input logic [31:0] addr,
                        input logic [31:0] erd,
                        input logic        eerr,
                        input int          lat);
    int k;
    bus0.req_valid  = 1'b1;
    bus0.req_we     = 1'b0;
    bus0.req_funct3 = f3;
    bus0.req_addr   = addr;
    @(negedge CLK);
    chk("m0_ready", 32'(bus0.req_ready), 1);
    @(posedge CLK);
    #1;
    bus0.req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (bus0.resp_valid !== 1'b1 && k < 10);
    chk("m0_latency", 32'(k), 32'(lat));
    chk("m0_rdata", bus0.resp_rdata, erd);
    chk("m0_err", 32'(bus0.resp_err), 32'(eerr));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    int m0_before;
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_funct3 = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    bus0.req_valid = 0;
    bus0.req_we = 0;
    bus0.req_funct3 = 0;
    bus0.req_addr = 0;
    bus0.req_wdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", 32'(bus.resp_err), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    exp_mem(32'h4, 0, 4'b0, 0);
    issue(0, F3_W, 32'h4, 0, 32'h11223344, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_B, 32'h3, 0, 32'hFFFFFF88, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_BU, 32'h3, 0, 32'h00000088, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    exp_mem(32'h4, 0, 4'b0, 0);
    issue(0, F3_W, 32'h2, 0, 32'h33448899, 0, 4, 0);
    exp_mem(32'h0, 1, 4'b0100, 32'h00EF0000);
    issue(1, F3_B, 32'h2, 32'hDEADBEEF, 0, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_W, 32'h0, 0, 32'h88EFAABB, 0, 3, 0);
    exp_mem(32'h0, 1, 4'b1000, 32'hBE000000);
    exp_mem(32'h4, 1, 4'b0111, 32'h00CAFEBA);
    issue(1, F3_W, 32'h3, 32'hCAFEBABE, 0, 0, 4, 0);
    exp_mem(32'h4, 0, 4'b0, 0);
    issue(0, F3_W, 32'h4, 0, 32'h11CAFEBA, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_W, 32'h0, 0, 32'hBEEFAABB, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    exp_mem(32'h4, 0, 4'b0, 0);
    issue(0, F3_H, 32'h3, 0, 32'hFFFFBABE, 0, 4, 0);
    exp_mem(32'hFFFFFFFC, 0, 4'b0, 0);
    exp_mem(32'h00000000, 0, 4'b0, 0);
    issue(0, F3_W, 32'hFFFFFFFE, 0,
          32'hAABB5566, 0, 4, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_HU, 32'h2, 0, 32'h0000BEEF, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_H, 32'h2, 0, 32'hFFFFBEEF, 0, 3, 0);
    exp_mem(32'h4, 1, 4'b1100, 32'hABCD0000);
    issue(1, F3_H, 32'h6, 32'h1234ABCD, 0, 0, 3, 0);
    exp_mem(32'h4, 0, 4'b0, 0);
    issue(0, F3_HU, 32'h6, 0, 32'h0000ABCD, 0, 3, 0);
    issue(0, 3'b011, 32'h0, 0, 0, 1, 2, 0);
    issue(1, F3_BU, 32'h0, 32'hFF, 0, 1, 2, 0);
    issue(0, 3'b110, 32'h0, 0, 0, 1, 2, 0);
    issue(1, F3_HU, 32'h4, 32'hFF, 0, 1, 2, 0);
    exp_mem(32'h4, 0, 4'b0, 0);
    issue(0, F3_W, 32'h4, 0, 32'hABCDFEBA, 0, 3, 0);
    exp_mem(32'h0, 0, 4'b0, 0);
    issue(0, F3_W, 32'h0, 0, 32'hBEEFAABB, 0, 3, 3);

    n = 0;
    while (rq.size() > 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_resp", 32'(rq.size()), 0);
    chk("drain_mem", 32'(mq.size()), 0);
    @(posedge CLK);
    #1;

    m0_before = m0_en;
    m0_req(F3_H, 32'h3, 0, 1, 2);
    m0_req(3'b011, 32'h0, 0, 1, 2);
    chk("m0_no_mem", 32'(m0_en - m0_before), 0);
    m0_req(F3_W, 32'h0, 32'h12345678, 0, 3);
    m0_req(F3_H, 32'h2, 32'h00001234, 0, 3);

    exp_mem(32'h0, 0, 4'b0, 0);
    exp_mem(32'h4, 0, 4'b0, 0);
    seen = n_resp;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h2;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(bus.mem_en && bus.mem_addr == 32'h4)
               && n < 10);
    chk("rst_reach_second",
        32'(bus.mem_en && bus.mem_addr == 32'h4), 1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("mid_rst_mem_en", 32'(bus.mem_en), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 1);
    chk("mid_rst_resp", 32'(bus.resp_valid), 0);
    repeat (6) @(posedge CLK);
    #1;
    chk("mid_rst_no_resp", 32'(n_resp - seen), 0);
    aq.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
